// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for the stopwatch input conditioning
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    HELD   = 2'd2,
    DISARM = 2'd3
  } db_state_t;

  localparam int CLK_HZ                  = 50_000_000;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_CLEAR_CYCLES    = 4;

  // Counter width that stays legal (>=1 bit) for tiny cycle counts.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-flop synchronizer, debounce FSM and one-clock press pulse
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  db_state_t       r_state;
  db_state_t       w_next;
  logic [CW-1:0]   r_cnt;
  logic            w_cnt_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_cnt_done = (r_cnt == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Held at zero in the stable states, so ARM/DISARM always start from 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == ARM || r_state == DISARM) begin
      if (!w_cnt_done) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (r_sync2) w_next = ARM;
      end
      ARM: begin
        if (!r_sync2)       w_next = IDLE;
        else if (w_cnt_done) w_next = HELD;
      end
      HELD: begin
        if (!r_sync2) w_next = DISARM;
      end
      DISARM: begin
        if (r_sync2)         w_next = HELD;
        else if (w_cnt_done) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_press = 1'b0;
    if (r_state == ARM && r_sync2 && w_cnt_done) begin
      o_press = 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_input_ctrl.sv
// rtl/stopwatch_input_ctrl.sv - button conditioning into pause, clear_n and preset strobes
module stopwatch_input_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CLEAR_CYCLES    = DEFAULT_CLEAR_CYCLES,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_startstop,
  input  logic btn_clear,
  input  logic btn_pre,
  input  logic btn_pre1,
  output logic pause,
  output logic clear_n,
  output logic pre,
  output logic pre1,
  output logic running
);

  localparam int              CLRW     = cnt_width(CLEAR_CYCLES + 1);
  localparam logic [CLRW-1:0] CLR_LOAD = CLRW'(CLEAR_CYCLES);

  logic [3:0]      w_btn_raw;
  logic [3:0]      w_btn_norm;
  logic [3:0]      w_press;
  logic            w_ss_p;
  logic            w_clr_p;
  logic            w_pre_p;
  logic            w_pre1_p;
  logic            w_clear_active;
  logic            r_pause;
  logic [CLRW-1:0] r_clr_cnt;
  logic            r_pre;
  logic            r_pre1;

  assign w_btn_raw  = {btn_pre1, btn_pre, btn_clear, btn_startstop};
  assign w_btn_norm = BTN_ACTIVE_LOW ? ~w_btn_raw : w_btn_raw;

  for (genvar g = 0; g < 4; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clock  (clock),
      .reset  (reset),
      .i_btn  (w_btn_norm[g]),
      .o_press(w_press[g])
    );
  end

  assign w_ss_p   = w_press[0];
  assign w_clr_p  = w_press[1];
  assign w_pre_p  = w_press[2];
  assign w_pre1_p = w_press[3];

  // Clear has priority over the start/stop toggle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pause <= 1'b1;
    end else if (w_clr_p) begin
      r_pause <= 1'b1;
    end else if (w_ss_p) begin
      r_pause <= ~r_pause;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clr_cnt <= '0;
    end else if (w_clr_p) begin
      r_clr_cnt <= CLR_LOAD;
    end else if (r_clr_cnt != '0) begin
      r_clr_cnt <= r_clr_cnt - CLRW'(1);
    end
  end

  assign w_clear_active = (r_clr_cnt != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pre  <= 1'b0;
      r_pre1 <= 1'b0;
    end else begin
      r_pre  <= w_pre_p  & ~w_clr_p & ~w_clear_active;
      r_pre1 <= w_pre1_p & ~w_clr_p & ~w_clear_active;
    end
  end

  assign pause   = r_pause;
  assign running = ~r_pause;
  assign clear_n = ~w_clear_active;
  assign pre     = r_pre;
  assign pre1    = r_pre1;

endmodule
